// File: rtl/uart_pkg.sv
// uart_pkg: baud table, divisor helpers and select type shared by the UART baud generator, TX and RX.
package uart_pkg;
   typedef logic [2:0] baud_sel_t;
   localparam int BAUD_TABLE [8] = '{1200, 2400, 4800, 9600, 19200, 38400, 57600, 115200};
   localparam int DEF_CLK_HZ = 100_000_000;
   localparam int DEF_OVS    = 16;
   function automatic int baud_div(input int clk_hz, input int ovs, input int idx);
      return (clk_hz + BAUD_TABLE[idx] * ovs / 2) / (BAUD_TABLE[idx] * ovs);
   endfunction
   // The table is ascending, so index 0 always carries the largest divisor.
   function automatic int div_width(input int clk_hz, input int ovs);
      return $clog2(baud_div(clk_hz, ovs, 0) + 1);
   endfunction
   localparam int DIV_W = div_width(DEF_CLK_HZ, DEF_OVS);
endpackage

// File: rtl/uart_baud_gen_if.sv
// uart_baud_gen_if: rate-select controls and tick outputs of the baud generator.
interface uart_baud_gen_if;
   import uart_pkg::*;
   logic      enable;
   baud_sel_t baud_sel;
   logic      sam_tick;
   logic      bd_tick;
   logic      aux_tick;
   logic      sel_chg;
   baud_sel_t cur_sel;
   modport master (output enable, baud_sel, input sam_tick, bd_tick, aux_tick, sel_chg, cur_sel);
   modport slave  (input enable, baud_sel, output sam_tick, bd_tick, aux_tick, sel_chg, cur_sel);
endinterface

// File: rtl/uart_baud_gen_tick_div.sv
// tick_div: modulo-(i_max+1) counter with enable and synchronous clear; o_wrap flags the wrapping cycle.
module tick_div #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_en,
   input  logic         i_clr,
   input  logic [W-1:0] i_max,
   output logic         o_wrap
);
   logic [W-1:0] r_cnt;
   assign o_wrap = i_en && r_cnt == i_max;
   always_ff @(posedge clk) begin
      if (rst || i_clr) r_cnt <= '0;
      else if (i_en) r_cnt <= o_wrap ? '0 : r_cnt + W'(1);
   end
endmodule

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: oversample, bit-rate and aux clock-enable generator with run-time baud selection.
// Define UART_BAUD_FRAC_EN to replace the integer sample divider with an exact-rate phase accumulator.
module uart_baud_gen
   import uart_pkg::*;
#(
   parameter int        CLK_HZ     = 100_000_000,
   parameter int        OVERSAMPLE = 16,
   parameter int        AUX_DIV    = 4,
   parameter baud_sel_t RESET_SEL  = 3'd3
) (
   input logic            sysclk,
   input logic            reset,
   uart_baud_gen_if.slave bus
);
   localparam int SUB_W = $clog2(OVERSAMPLE);
   localparam int AUX_W = $clog2(AUX_DIV);
   baud_sel_t r_sel_q, r_cur_sel;
   logic      r_sam_tick, r_bd_tick, r_aux_tick, r_sel_chg;
   logic      w_chg, w_sam_wrap, w_bd_wrap, w_aux_wrap;
   assign w_chg = r_sel_q != r_cur_sel;
`ifdef UART_BAUD_FRAC_EN
   localparam int ACC_W = $clog2(CLK_HZ + BAUD_TABLE[7] * OVERSAMPLE);
   logic [ACC_W-1:0] r_acc, w_sum;
   logic [ACC_W-1:0] w_inc [8];
   for (genvar i = 0; i < 8; i++) begin : g_inc
      assign w_inc[i] = ACC_W'(BAUD_TABLE[i] * OVERSAMPLE);
   end
   assign w_sum      = r_acc + w_inc[r_cur_sel];
   assign w_sam_wrap = bus.enable && w_sum >= ACC_W'(CLK_HZ);
   always_ff @(posedge sysclk) begin
      if (reset || w_chg) r_acc <= '0;
      else if (bus.enable) r_acc <= w_sam_wrap ? w_sum - ACC_W'(CLK_HZ) : w_sum;
   end
`else
   localparam int DIV_W = div_width(CLK_HZ, OVERSAMPLE);
   logic [DIV_W-1:0] w_div_max [8];
   for (genvar i = 0; i < 8; i++) begin : g_div
      assign w_div_max[i] = DIV_W'(baud_div(CLK_HZ, OVERSAMPLE, i) - 1);
   end
   tick_div #(.W(DIV_W)) u_sam (
      .clk(sysclk), .rst(reset), .i_en(bus.enable), .i_clr(w_chg),
      .i_max(w_div_max[r_cur_sel]), .o_wrap(w_sam_wrap)
   );
`endif
   tick_div #(.W(SUB_W)) u_sub (
      .clk(sysclk), .rst(reset), .i_en(w_sam_wrap), .i_clr(w_chg),
      .i_max(SUB_W'(OVERSAMPLE - 1)), .o_wrap(w_bd_wrap)
   );
   tick_div #(.W(AUX_W)) u_aux (
      .clk(sysclk), .rst(reset), .i_en(1'b1), .i_clr(1'b0),
      .i_max(AUX_W'(AUX_DIV - 1)), .o_wrap(w_aux_wrap)
   );
   // A rate change takes priority over any divider wrap landing on the same edge.
   always_ff @(posedge sysclk) begin
      if (reset) begin
         r_sel_q    <= RESET_SEL;
         r_cur_sel  <= RESET_SEL;
         r_sel_chg  <= 1'b0;
         r_sam_tick <= 1'b0;
         r_bd_tick  <= 1'b0;
         r_aux_tick <= 1'b0;
      end else begin
         r_sel_q    <= bus.baud_sel;
         r_cur_sel  <= w_chg ? r_sel_q : r_cur_sel;
         r_sel_chg  <= w_chg;
         r_sam_tick <= w_sam_wrap && !w_chg;
         r_bd_tick  <= w_bd_wrap && !w_chg;
         r_aux_tick <= w_aux_wrap;
      end
   end
   assign bus.sam_tick = r_sam_tick;
   assign bus.bd_tick  = r_bd_tick;
   assign bus.aux_tick = r_aux_tick;
   assign bus.sel_chg  = r_sel_chg;
   assign bus.cur_sel  = r_cur_sel;
endmodule
